// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the load-lane extension helper.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      RS_IDLE,
      RS_WAIT,
      RS_RESP
   } resp_state_t;

   localparam int MAX_WAIT_STATES = 15;

   function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                               input logic is_half,
                                               input logic zero_ext);
      if (is_half)
         return zero_ext ? {16'h0000, lane} : {{16{lane[15]}}, lane};
      return zero_ext ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
   endfunction

endpackage

// File: rtl/data_mem_responder_load_store_align.sv
// Combinational lane steering: byte enables and replicated store data going in,
// lane extraction plus sign/zero extension coming out, and the alignment check.
module load_store_align
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   input  logic        zero_ext,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   logic [15:0] lane;

   assign lane = 16'(rword >> {addr_lo, 3'b000});

   always_comb begin
      byte_en    = 4'b0000;
      wdata_lane = 32'h0000_0000;
      rdata_ext  = 32'h0000_0000;
      misaligned = 1'b0;
      case (mem_size_t'(size))
         MEM_BYTE: begin
            byte_en    = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            rdata_ext  = extend_lane(lane, 1'b0, zero_ext);
         end
         MEM_HALF: begin
            misaligned = addr_lo[0];
            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
            rdata_ext  = extend_lane(lane, 1'b1, zero_ext);
         end
         MEM_WORD: begin
            misaligned = |addr_lo;
            byte_en    = 4'b1111;
            wdata_lane = wdata;
            rdata_ext  = rword;
         end
         // the reserved size encoding is reported like a misaligned access
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// programmable wait states, byte-lane RAM and a held response channel.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   resp_state_t state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;

   logic        write_reg;
   logic [31:0] addr_reg;
   logic [1:0]  size_reg;
   logic        zext_reg;
   logic [31:0] wdata_reg;

   logic        cur_write;
   logic [31:0] cur_addr;
   logic [1:0]  cur_size;
   logic        cur_zext;
   logic [31:0] cur_wdata;

   logic        accept;
   logic        entering_resp;
   logic        out_of_range;
   logic        misaligned;
   logic        access_err;
   logic        ram_we;
   logic [IDX_W-1:0] ram_idx;
   logic [3:0]  byte_en;
   logic [31:0] wdata_lane;
   logic [31:0] rword;
   logic [31:0] rdata_ext;

   assign req_ready = (state_reg == RS_IDLE);
   assign accept    = req_valid && req_ready;

   // In IDLE the live request is the one being decided; afterwards the latched copy.
   // This lets a zero-wait-state build commit its store on the accepting edge.
   assign cur_write = (state_reg == RS_IDLE) ? req_write    : write_reg;
   assign cur_addr  = (state_reg == RS_IDLE) ? req_addr     : addr_reg;
   assign cur_size  = (state_reg == RS_IDLE) ? req_size     : size_reg;
   assign cur_zext  = (state_reg == RS_IDLE) ? req_unsigned : zext_reg;
   assign cur_wdata = (state_reg == RS_IDLE) ? req_wdata    : wdata_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= RS_IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         RS_IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_next = RS_RESP;
               end else begin
                  state_next = RS_WAIT;
                  cnt_next   = CNT_INIT;
               end
            end
         end
         RS_WAIT: begin
            if (cnt_reg == 4'd0) state_next = RS_RESP;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         RS_RESP: begin
            if (rsp_ready) state_next = RS_IDLE;
         end
         default: state_next = RS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_reg <= 1'b0;
         addr_reg  <= 32'h0000_0000;
         size_reg  <= 2'b00;
         zext_reg  <= 1'b0;
         wdata_reg <= 32'h0000_0000;
      end else if (accept) begin
         write_reg <= req_write;
         addr_reg  <= req_addr;
         size_reg  <= req_size;
         zext_reg  <= req_unsigned;
         wdata_reg <= req_wdata;
      end
   end

   load_store_align u_align (
      .size       (cur_size),
      .addr_lo    (cur_addr[1:0]),
      .wdata      (cur_wdata),
      .rword      (rword),
      .zero_ext   (cur_zext),
      .byte_en    (byte_en),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext),
      .misaligned (misaligned)
   );

   assign out_of_range  = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign access_err    = misaligned || out_of_range;
   assign entering_resp = (state_next == RS_RESP) && (state_reg != RS_RESP);
   // rst gate keeps a request sitting on the bus during reset from writing the RAM
   assign ram_we        = rst && entering_resp && cur_write && !access_err;
   assign ram_idx       = cur_addr[IDX_W+1:2];

   // One byte-wide RAM per lane; the word is read on accept and stays put until the next one.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rbyte_reg;

      always_ff @(posedge clk) begin
         if (accept)
            rbyte_reg <= lane_mem[ram_idx];
         if (ram_we && byte_en[gi])
            lane_mem[ram_idx] <= wdata_lane[8*gi +: 8];
      end

      assign rword[8*gi +: 8] = rbyte_reg;
   end

   assign rsp_valid = (state_reg == RS_RESP);
   assign rsp_error = rsp_valid && access_err;
   assign rsp_rdata = (rsp_valid && !access_err && !cur_write) ? rdata_ext : 32'h0000_0000;

endmodule
